// File: rtl/shift_tx_if.sv
// Word handshake plus framed serial output bundle for shift_tx.
// The slave modport is the transmitter side and the master modport is the word source/line observer.
interface shift_tx_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] data_i;
   logic             valid_i;
   logic             ready_o;
   logic             sdata_o;
   logic             sclk_o;
   logic             frame_o;
   logic             done_o;

   modport slave (
      input  data_i,
      input  valid_i,
      output ready_o,
      output sdata_o,
      output sclk_o,
      output frame_o,
      output done_o
   );

   modport master (
      output data_i,
      output valid_i,
      input  ready_o,
      input  sdata_o,
      input  sclk_o,
      input  frame_o,
      input  done_o
   );
endinterface

// File: rtl/shift_tx.sv
// Parallel-to-serial transmitter: one word per valid/ready handshake, framed, with a divided bit clock.
// Data changes on sclk falling edges; one GAP cycle after each word keeps frame low for at least 2 cycles.
module shift_tx #(
   parameter int WIDTH     = 16,
   parameter int CLK_DIV   = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   shift_tx_if.slave   bus
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   shreg, shreg_nxt;
   logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
   logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
   logic               ready, ready_nxt;
   logic               sdata, sdata_nxt;
   logic               sclk, sclk_nxt;
   logic               frame, frame_nxt;
   logic               done, done_nxt;

   logic               first_bit;
   logic               next_bit;
   logic [WIDTH-1:0]   shreg_shifted;

   assign bus.ready_o = ready;
   assign bus.sdata_o = sdata;
   assign bus.sclk_o  = sclk;
   assign bus.frame_o = frame;
   assign bus.done_o  = done;

   // The register always holds the bit currently on the line at the edge position
   // MSB (or LSB), so the next bit sits one place further in.
   assign first_bit     = (MSB_FIRST != 0) ? bus.data_i[WIDTH-1] : bus.data_i[0];
   assign next_bit      = (MSB_FIRST != 0) ? shreg[WIDTH-2]      : shreg[1];
   assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                           : {1'b0, shreg[WIDTH-1:1]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         shreg   <= '0;
         div_cnt <= '0;
         bit_cnt <= '0;
         ready   <= 1'b1;
         sdata   <= 1'b0;
         sclk    <= 1'b0;
         frame   <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         div_cnt <= div_cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         ready   <= ready_nxt;
         sdata   <= sdata_nxt;
         sclk    <= sclk_nxt;
         frame   <= frame_nxt;
         done    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      div_cnt_nxt = div_cnt;
      bit_cnt_nxt = bit_cnt;
      ready_nxt   = ready;
      sdata_nxt   = sdata;
      sclk_nxt    = sclk;
      frame_nxt   = frame;
      done_nxt    = done;

      case (state)
         IDLE: begin
            if (bus.valid_i && ready) begin
               shreg_nxt   = bus.data_i;
               ready_nxt   = 1'b0;
               frame_nxt   = 1'b1;
               sdata_nxt   = first_bit;
               sclk_nxt    = 1'b0;
               div_cnt_nxt = '0;
               bit_cnt_nxt = '0;
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_nxt = '0;
               if (!sclk) begin
                  sclk_nxt = 1'b1;
               end else begin
                  sclk_nxt = 1'b0;
                  if (bit_cnt == BIT_LAST) begin
                     frame_nxt = 1'b0;
                     sdata_nxt = 1'b0;
                     done_nxt  = 1'b1;
                     state_nxt = GAP;
                  end else begin
                     bit_cnt_nxt = bit_cnt + 1'b1;
                     shreg_nxt   = shreg_shifted;
                     sdata_nxt   = next_bit;
                  end
               end
            end else begin
               div_cnt_nxt = div_cnt + 1'b1;
            end
         end
         GAP: begin
            done_nxt  = 1'b0;
            ready_nxt = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_shift_tx.sv
// Bench for shift_tx (WIDTH=16, CLK_DIV=2): scoreboard of accepted words checked at each done pulse,
// plus frame length, gap, latency, reset and LSB-first checks.
module tb_shift_tx;
   localparam int W       = 16;
   localparam int DIV     = 2;
   localparam int FRAME_C = 2 * DIV * W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   shift_tx_if #(.WIDTH(W)) m ();
   shift_tx_if #(.WIDTH(W)) l ();

   shift_tx #(.WIDTH(W), .CLK_DIV(DIV), .MSB_FIRST(1)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (m)
   );

   shift_tx #(.WIDTH(W), .CLK_DIV(DIV), .MSB_FIRST(0)) dut_lsb (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (l)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Scoreboard and line monitor, sampled on the falling clock edge.
   logic [W-1:0] sb_q[$];
   logic [W-1:0] word;
   int  cyc = 0, acc_edge = 0, n_acc = 0, n_done = 0;
   int  nbits = 0, frame_len = 0, gap_cnt = 0, last_gap = 0;
   logic prev_sclk = 1'b0, prev_frame = 1'b0, done_prev = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         nbits = 0; frame_len = 0;
         prev_sclk = 1'b0; prev_frame = 1'b0; done_prev = 1'b0;
      end else begin
         if (m.valid_i && m.ready_o) begin
            sb_q.push_back(m.data_i);
            acc_edge = cyc + 1;
            n_acc++;
         end
         if (m.sclk_o && !prev_sclk) begin
            word = {word[W-2:0], m.sdata_o};
            nbits++;
         end
         if (m.frame_o && !prev_frame) begin
            last_gap  = gap_cnt;
            gap_cnt   = 0;
            frame_len = 0;
         end
         if (!m.frame_o && prev_frame)
            check("frame_len", frame_len, FRAME_C);
         if (m.frame_o) frame_len++; else gap_cnt++;
         if (done_prev) begin
            check("done_width", m.done_o, 1'b0);
            check("ready_ret", m.ready_o, 1'b1);
         end
         if (m.done_o) begin
            n_done++;
            if (sb_q.size() == 0) begin
               check("unexp_done", 1, 0);
            end else begin
               check("word", word, sb_q.pop_front());
               check("nbits", nbits, W);
               check("done_lat", cyc - acc_edge, FRAME_C);
            end
            nbits = 0;
         end
         prev_sclk  = m.sclk_o;
         prev_frame = m.frame_o;
         done_prev  = m.done_o;
      end
   end

   task automatic wait_acc();
      int start = n_acc;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); #1;
         if (n_acc != start) break;
      end
      check("accept", n_acc - start, 1);
   endtask

   task automatic wait_idle();
      logic ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); #1;
         if (m.ready_o && !m.frame_o && sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle", ok, 1'b1);
   endtask

   task automatic send(input logic [W-1:0] d);
      @(posedge clk); #1;
      m.data_i  = d;
      m.valid_i = 1'b1;
      wait_acc();
      @(posedge clk); #1;
      m.valid_i = 1'b0;
   endtask

   logic [W-1:0] lword;
   int lbits, d0;
   logic lprev;

   initial begin
      m.data_i = '0; m.valid_i = 1'b0;
      l.data_i = '0; l.valid_i = 1'b0;

      // Asynchronous reset, checked before the first clock edge.
      #1 rst = 1'b1;
      #1;
      check("rst_ready", m.ready_o, 1'b1);
      check("rst_sdata", m.sdata_o, 1'b0);
      check("rst_sclk",  m.sclk_o,  1'b0);
      check("rst_frame", m.frame_o, 1'b0);
      check("rst_done",  m.done_o,  1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("ready_after_rst", m.ready_o, 1'b1);

      send(16'hA5C3);
      wait_idle();

      // Word changes while busy must not disturb the word in flight.
      send(16'h5A3C);
      repeat (10) @(posedge clk);
      #1 m.data_i = 16'h1234; m.valid_i = 1'b1;
      wait_acc();
      @(posedge clk); #1 m.valid_i = 1'b0;
      wait_idle();

      // Back-to-back with valid held high.
      d0 = n_done;
      @(posedge clk); #1 m.data_i = 16'hFFFF; m.valid_i = 1'b1;
      wait_acc();
      @(posedge clk); #1 m.data_i = 16'h0000;
      wait_acc();
      @(posedge clk); #1 m.valid_i = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      check("b2b_gap", last_gap, 2);
      wait_idle();
      check("b2b_dones", n_done - d0, 2);

      // Reset in the middle of a word.
      send(16'h0F0F);
      for (int i = 0; i < 400 && nbits < 7; i++) @(negedge clk);
      check("reach_bit7", nbits, 7);
      d0 = n_done;
      @(posedge clk); #2 rst = 1'b1;
      #1;
      check("mid_rst_frame", m.frame_o, 1'b0);
      check("mid_rst_sclk",  m.sclk_o,  1'b0);
      check("mid_rst_sdata", m.sdata_o, 1'b0);
      check("mid_rst_ready", m.ready_o, 1'b1);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      check("mid_rst_no_done", n_done - d0, 0);
      check("mid_rst_sb_empty", sb_q.size(), 0);
      send(16'h8001);
      wait_idle();

      // LSB-first instance.
      @(posedge clk); #1 l.data_i = 16'h0001; l.valid_i = 1'b1;
      @(posedge clk); #1 l.valid_i = 1'b0;
      lword = '0; lbits = 0; lprev = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (l.sclk_o && !lprev) begin
            if (lbits < W) lword[lbits] = l.sdata_o;
            if (lbits == 0) check("lsb_first_bit", l.sdata_o, 1'b1);
            lbits++;
         end
         lprev = l.sclk_o;
         if (l.done_o) break;
      end
      check("lsb_nbits", lbits, W);
      check("lsb_word", lword, 16'h0001);

      check("total_dones", n_done, 6);
      check("sb_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
